ps2_key_decoder: RTL and testbench

Consumes validated PS/2 scan-code bytes from the PS/2 serial receiver and turns them into key press/release events for the game/control logic. Resolves E0 (extended) and F0 (break) prefixes, tracks the held state of the four arrow keys and key "1", and reports keyboard self-test results (AA/FC). Events are queued in a small FIFO behind a valid/ready handshake.

---
 rtl/ps2_kb_pkg.sv | 62 ++++++
 rtl/ps2_key_decoder_if.sv | 29 ++
 rtl/ps2_event_fifo.sv | 81 ++++++++
 rtl/ps2_key_decoder.sv | 134 +++++++++++++
 tb/tb_ps2_key_decoder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_kb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_kb_pkg                                                       |
// | Brief   : Scan codes, key ids, FSM states and event format for the decoder |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ps2_kb_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_AA    = 8'hAA;
    localparam logic [7:0] SC_FC    = 8'hFC;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ONE   = 8'h16;

    localparam int         NUM_KEYS  = 5;
    localparam logic [2:0] KEY_UP    = 3'd0;
    localparam logic [2:0] KEY_DOWN  = 3'd1;
    localparam logic [2:0] KEY_LEFT  = 3'd2;
    localparam logic [2:0] KEY_RIGHT = 3'd3;
    localparam logic [2:0] KEY_ONE   = 3'd4;

    // Event word layout: {break, key[2:0]}
    localparam int EV_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_E0   = 2'd1,
        S_F0   = 2'd2,
        S_E0F0 = 2'd3
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] key;
    } keymap_t;

    // Arrow codes are accepted with or without the E0 prefix (keypad arrows
    // count); "1" only exists on the main block, so it requires ext=0.
    function automatic keymap_t map_key(input logic [7:0] c, input logic ext);
        keymap_t m;
        m.hit = 1'b1;
        m.key = KEY_UP;
        case (c)
            SC_UP:    m.key = KEY_UP;
            SC_DOWN:  m.key = KEY_DOWN;
            SC_LEFT:  m.key = KEY_LEFT;
            SC_RIGHT: m.key = KEY_RIGHT;
            SC_ONE: begin
                m.key = KEY_ONE;
                m.hit = !ext;
            end
            default:  m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_key_decoder_if                                               |
// | Brief   : Scan-code input strobe and key-event valid/ready channel         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ps2_key_decoder_if;

    logic       code_valid;
    logic [7:0] code;
    logic       code_err;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_key;
    logic       ev_break;

    // master: byte source and event consumer; slave: the decoder
    modport master (
        output code_valid, code, code_err, ev_ready,
        input  ev_valid, ev_key, ev_break
    );

    modport slave (
        input  code_valid, code, code_err, ev_ready,
        output ev_valid, ev_key, ev_break
    );

endinterface
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_event_fifo                                                   |
// | Brief   : Synchronous event FIFO with sticky overflow on dropped pushes    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    output logic                  full,
    input  wire logic             pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  empty,
    output logic                  overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             ovf_q,    ovf_d;

    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign pop_data = mem_q[rd_ptr_q];
    assign overflow = ovf_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still taken when the head leaves.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push && !w_push_ok);
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_key_decoder                                                  |
// | Brief   : PS/2 scan-code prefix FSM, key bitmap, self-test flags, events   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_key_decoder
    import ps2_kb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    ps2_key_decoder_if.slave      bus,
    output logic [NUM_KEYS-1:0]   key_down,
    output logic                  kb_ok,
    output logic                  kb_err,
    output logic                  ev_overflow
);

    localparam int               CNT_W    = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    logic                kb_ok_q,    kb_ok_d;
    logic                kb_err_q,   kb_err_d;

    logic                w_ext;
    logic                w_brk;
    keymap_t             w_map;
    logic                w_push;
    logic [EV_W-1:0]     w_push_data;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic [EV_W-1:0]     w_pop_data;

    assign w_ext = (state_q == S_E0) || (state_q == S_E0F0);
    assign w_brk = (state_q == S_F0) || (state_q == S_E0F0);
    assign w_map = map_key(bus.code, w_ext);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_down_d  = key_down_q;
        kb_ok_d     = kb_ok_q;
        kb_err_d    = kb_err_q;
        w_push      = 1'b0;
        w_push_data = '0;
        if (bus.code_valid) begin
            cnt_d = '0;
            if (bus.code_err) begin
                state_d = S_IDLE;
            end else if (bus.code == SC_E0) begin
                state_d = S_E0;
            end else if (bus.code == SC_F0) begin
                state_d = w_ext ? S_E0F0 : S_F0;
            end else begin
                state_d = S_IDLE;
                if (!w_ext && !w_brk && bus.code == SC_AA) begin
                    kb_ok_d    = 1'b1;
                    key_down_d = '0;
                end else if (!w_ext && !w_brk && bus.code == SC_FC) begin
                    kb_err_d   = 1'b1;
                    kb_ok_d    = 1'b0;
                    key_down_d = '0;
                end else if (w_map.hit) begin
                    // Typematic repeats and releases of unheld keys fall through
                    if (!w_brk && !key_down_q[w_map.key]) begin
                        key_down_d[w_map.key] = 1'b1;
                        w_push                = 1'b1;
                        w_push_data           = {1'b0, w_map.key};
                    end else if (w_brk && key_down_q[w_map.key]) begin
                        key_down_d[w_map.key] = 1'b0;
                        w_push                = 1'b1;
                        w_push_data           = {1'b1, w_map.key};
                    end
                end
            end
        end else if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            key_down_q <= '0;
            kb_ok_q    <= 1'b0;
            kb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_down_q <= key_down_d;
            kb_ok_q    <= kb_ok_d;
            kb_err_q   <= kb_err_d;
        end
    end

    assign w_pop = !w_empty && bus.ev_ready;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (w_push),
        .push_data (w_push_data),
        .full      (w_full),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .empty     (w_empty),
        .overflow  (ev_overflow)
    );

    assign bus.ev_valid = !w_empty;
    assign bus.ev_break = w_pop_data[3];
    assign bus.ev_key   = w_pop_data[2:0];
    assign key_down     = key_down_q;
    assign kb_ok        = kb_ok_q;
    assign kb_err       = kb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ps2_key_decoder                                               |
// | Brief   : Directed scoreboard bench for the PS/2 key decoder               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_key_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] key_down;
    logic       kb_ok;
    logic       kb_err;
    logic       ev_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q [$];

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(
        .FIFO_DEPTH     (4),
        .PREFIX_TIMEOUT (50000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus),
        .key_down    (key_down),
        .kb_ok       (kb_ok),
        .kb_err      (kb_err),
        .ev_overflow (ev_overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head event is matched against the scoreboard
    always @(negedge CLK) begin
        if (!RST && bus.ev_valid && bus.ev_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL event_unexpected: got brk=%0d key=%0d expected none",
                         bus.ev_break, bus.ev_key);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if ({bus.ev_break, bus.ev_key} !== e) begin
                    n_fail++;
                    $display("FAIL event: got brk=%0d key=%0d expected brk=%0d key=%0d",
                             bus.ev_break, bus.ev_key, e[3], e[2:0]);
                end
            end
        end
    end

    // Presents one byte for exactly one cycle; entered and left at posedge+1
    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        bus.code       = b;
        bus.code_err   = err;
        bus.code_valid = 1'b1;
        @(posedge CLK);
        #1;
        bus.code_valid = 1'b0;
        bus.code_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
    endtask

    initial begin
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;
        bus.code_err   = 1'b0;
        bus.ev_ready   = 1'b1;
        idle(3);
        RST = 1'b0;

        check("rst_ev_valid", bus.ev_valid, 0);
        check("rst_key_down", key_down, 0);
        check("rst_kb_ok", kb_ok, 0);
        check("rst_kb_err", kb_err, 0);
        check("rst_overflow", ev_overflow, 0);

        // Extended UP press and release
        exp_q.push_back(4'b0_000);
        send(8'hE0); send(8'h75);
        check("up_press_bitmap", key_down, 5'b00001);
        exp_q.push_back(4'b1_000);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("up_release_bitmap", key_down, 5'b00000);

        // Typematic ONE, release, then extended ONE is ignored
        exp_q.push_back(4'b0_100);
        send(8'h16); send(8'h16); send(8'h16);
        check("one_held", key_down, 5'b10000);
        exp_q.push_back(4'b1_100);
        send(8'hF0); send(8'h16);
        check("one_released", key_down, 5'b00000);
        send(8'hE0); send(8'h16);
        check("e0_one_ignored", key_down, 5'b00000);
        idle(3);
        check("no_pending_events", exp_q.size(), 0);

        // Pending E0 expires, DOWN resolves as a plain press
        send(8'hE0);
        idle(50000);
        exp_q.push_back(4'b0_001);
        send(8'h72);
        check("timeout_down_press", key_down, 5'b00010);
        exp_q.push_back(4'b1_001);
        send(8'hF0); send(8'h72);
        check("down_released", key_down, 5'b00000);
        idle(3);

        // Fill the FIFO, overflow on the fifth, push-with-pop while full
        bus.ev_ready = 1'b0;
        exp_q.push_back(4'b0_000); send(8'h75);
        exp_q.push_back(4'b0_001); send(8'h72);
        exp_q.push_back(4'b0_010); send(8'h6B);
        exp_q.push_back(4'b0_011); send(8'h74);
        check("full_no_overflow_yet", ev_overflow, 0);
        send(8'h16);
        check("overflow_set", ev_overflow, 1);
        check("bitmap_all_held", key_down, 5'b11111);
        send(8'hF0);
        exp_q.push_back(4'b1_100);
        bus.ev_ready = 1'b1;
        send(8'h16);
        bus.ev_ready = 1'b0;
        check("fifo_full_after_swap", bus.ev_valid, 1);
        check("bitmap_one_released", key_down, 5'b01111);
        idle(2);
        check("head_stable_key", bus.ev_key, 3'd1);
        check("head_stable_brk", bus.ev_break, 0);
        bus.ev_ready = 1'b1;
        idle(6);
        check("drained", bus.ev_valid, 0);
        check("drained_scoreboard", exp_q.size(), 0);

        // Self-test bytes clear the bitmap and produce no events
        send(8'hAA);
        check("aa_bitmap", key_down, 5'b00000);
        check("aa_kb_ok", kb_ok, 1);
        check("aa_kb_err", kb_err, 0);
        send(8'hFC);
        check("fc_kb_err", kb_err, 1);
        check("fc_kb_ok", kb_ok, 0);
        idle(3);
        check("selftest_no_events", bus.ev_valid, 0);

        // Errored F0 is dropped, so 74 is a press
        send(8'hF0, 1'b1);
        exp_q.push_back(4'b0_011);
        send(8'h74);
        check("err_then_right_press", key_down, 5'b01000);
        idle(3);

        // Reset after E0 loses the prefix and clears sticky state
        send(8'hE0);
        pulse_reset();
        check("rst_mid_bitmap", key_down, 0);
        check("rst_mid_kb_err", kb_err, 0);
        check("rst_mid_overflow", ev_overflow, 0);
        exp_q.push_back(4'b0_000);
        send(8'h75);
        check("post_rst_up", key_down, 5'b00001);
        send(8'hE0);
        pulse_reset();
        exp_q.push_back(4'b0_100);
        send(8'h16);
        check("post_rst_one_plain", key_down, 5'b10000);

        begin
            int budget;
            budget = 20;
            while (exp_q.size() != 0 && budget > 0) begin
                idle(1);
                budget--;
            end
        end
        check("final_scoreboard_empty", exp_q.size(), 0);
        check("final_fifo_empty", bus.ev_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
